// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory target for the RV32I MEM stage.
// Define DMEM_OOB_ERR_EN to flag out-of-range addresses instead of aliasing them.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic        req, oob, go_resp, unused;
  logic [31:0] rd_addr, off;
  logic [AW-1:0] idx;
  // With LATENCY=1 the read happens on the accept edge, before the address is latched.
  assign req     = state == IDLE && |(dmem_rmask | dmem_wmask);
  assign rd_addr = state == IDLE ? dmem_addr : addr_q;
  assign off     = {rd_addr[31:2], 2'b00} - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign go_resp = (req && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
  assign busy    = req || state != IDLE;
  assign unused  = ^{rd_addr[1:0], off};
`ifdef DMEM_OOB_ERR_EN
  assign oob = off >= 32'(DEPTH_WORDS * 4);
`else
  assign oob = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
      dmem_err   <= 1'b0;
    end else begin
      dmem_resp  <= go_resp;
      dmem_rdata <= go_resp && !oob ? mem[idx] : '0;
      dmem_err   <= go_resp && oob;
      case (state)
        IDLE: if (req) begin
          addr_q  <= dmem_addr;
          wmask_q <= dmem_wmask;
          wdata_q <= dmem_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= cnt == 4'd1 ? RESP : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Write commits on the edge ending RESP; dmem_err suppresses out-of-range writes.
  always_ff @(posedge clk) begin
    if (state == RESP && !dmem_err)
      for (int i = 0; i < 4; i++)
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 2 and 1.
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h1ECE_B000;
  localparam int LAT = 2;
  logic        clk = 0, rst_n = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0]  rmask = 0, wmask = 0;
  logic        resp, err, busy;
  logic [31:0] addr1 = 0, wdata1 = 0, rdata1;
  logic [3:0]  rmask1 = 0, wmask1 = 0;
  logic        resp1, err1, busy1;
  int passed = 0, total = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr), .dmem_rmask(rmask), .dmem_wmask(wmask),
    .dmem_wdata(wdata), .dmem_rdata(rdata), .dmem_resp(resp), .dmem_err(err), .busy(busy));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr1), .dmem_rmask(rmask1), .dmem_wmask(wmask1),
    .dmem_wdata(wdata1), .dmem_rdata(rdata1), .dmem_resp(resp1), .dmem_err(err1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic xact(input string tag, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    addr = a; rmask = rm; wmask = wm; wdata = wd;
    #1 check({tag, "_busy"}, 32'(busy), 1);
    @(posedge clk);
    #1 addr = 0; rmask = 0; wmask = 0; wdata = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (resp) break;
    end
    check({tag, "_lat"}, 32'(n), LAT);
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_err"}, 32'(err), {31'b0, exp_err});
    @(negedge clk);
    check({tag, "_pulse"}, 32'(resp), 0);
  endtask

  initial begin
    logic [7:0] hist;
    @(negedge clk);
    check("rst_resp", 32'(resp), 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    dut.mem[0] = 32'hDEAD_BEEF;
    dut.mem[1] = 32'h0;
    dut.mem[2] = 32'hAAAA_AAAA;
    dut.mem[5] = 32'h1234_5678;
    dut1.mem[3] = 32'hC0FF_EE00;
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk) check("idle_noresp", 32'({resp, busy}), 0);

    xact("rd0", BASE, 4'hF, 4'h0, 0, 32'hDEAD_BEEF, 0);
    xact("rd0_bytemask", BASE + 2, 4'b0001, 4'h0, 0, 32'hDEAD_BEEF, 0);
    xact("wr1", BASE + 4, 4'h0, 4'b0110, 32'h1122_3344, 32'h0, 0);
    xact("rd1", BASE + 4, 4'hF, 4'h0, 0, 32'h0022_3300, 0);
    xact("rmw2", BASE + 8, 4'hF, 4'hF, 32'h5555_5555, 32'hAAAA_AAAA, 0);
    xact("rd2", BASE + 8, 4'hF, 4'h0, 0, 32'h5555_5555, 0);

    // Request held through RESP: ignored there, re-accepted the cycle after.
    @(negedge clk);
    addr = BASE; rmask = 4'hF;
    hist = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hist[i] = resp;
      if (resp) check("b2b_rdata", rdata, 32'hDEAD_BEEF);
    end
    rmask = 0; addr = 0;
    check("b2b_pattern", 32'(hist), 32'b010010);

    // LATENCY=1: held read gives a pulse every other cycle.
    @(negedge clk);
    addr1 = BASE + 12; rmask1 = 4'hF;
    hist = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hist[i] = resp1;
      if (resp1) check("l1_rdata", rdata1, 32'hC0FF_EE00);
    end
    rmask1 = 0; addr1 = 0;
    check("l1_pattern", 32'(hist), 32'b0101_0101);

    // Reset during WAIT of a write aborts it.
    @(negedge clk);
    addr = BASE + 20; wmask = 4'hF; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 addr = 0; wmask = 0; wdata = 0;
    @(negedge clk);
    rst_n = 0;
    #1 check("abort_outs", 32'({resp, err, busy}) | rdata, 0);
    @(negedge clk) check("abort_noresp", 32'(resp), 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk) check("abort_idle", 32'({resp, busy}), 0);
    check("abort_word", dut.mem[5], 32'h1234_5678);
    xact("rd5", BASE + 20, 4'hF, 4'h0, 0, 32'h1234_5678, 0);

`ifdef DMEM_OOB_ERR_EN
    xact("oob", BASE + 4096, 4'hF, 4'h0, 0, 32'h0, 1);
`else
    xact("alias", BASE + 4096, 4'hF, 4'h0, 0, 32'hDEAD_BEEF, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32I core: the target end of the dmem request interface that the MEM stage drives (word-aligned address, read/write byte masks, write data). It captures one request at a time, services it from an on-chip byte-writable word array after a fixed, parameterised latency, and returns a single-cycle response with read data. It sits outside the pipeline as the memory model and adaptor; the core stalls on it until `dmem_resp`.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words stored; power of two, ≥ 4.
- `LATENCY`, 2: cycles from accept to `dmem_resp`; valid range 1 to 15.
- `BASE_ADDR`, 32'h1ECE_B000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dmem_addr`  in  32  request byte address; bits [1:0] ignored.
- `dmem_rmask`  in  4  read byte mask; nonzero means read request.
- `dmem_wmask`  in  4  write byte mask; nonzero means write request.
- `dmem_wdata`  in  32  write data; byte i written when `dmem_wmask[i]`.
- `dmem_rdata`  out  32  read data; valid only while `dmem_resp`=1.
- `dmem_resp`  out  1  one-cycle completion pulse.
- `dmem_err`  out  1  error flag qualified by `dmem_resp` (see Configuration).
- `busy`  out  1  high from accept cycle through response cycle.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter is used in WAIT.
- IDLE: request present when `(dmem_rmask | dmem_wmask) != 0`. On request, latch addr, rmask, wmask and wdata; load counter with `LATENCY-1`; go to WAIT, or to RESP directly when `LATENCY`=1.
- WAIT: decrement counter each cycle; at 0 go to RESP. Inputs are ignored; the requestor holds them stable.
- RESP:
  - `dmem_resp`=1.
  - `dmem_rdata` = full stored word at the latched index, before any write. The word is not masked by rmask; byte and half extraction belongs to writeback.
  - Write bytes selected by the latched wmask are committed at the clock edge ending RESP.
  - Always return to IDLE. Inputs in the RESP cycle are ignored even if nonzero.
- Index = `(latched_addr - BASE_ADDR) >> 2`, taking the low log2(`DEPTH_WORDS`) bits.
- Read and write masks both nonzero: treated as one transaction. rdata returns the pre-write word, and the write is committed.
- Zero masks in IDLE: no request, stay in IDLE, outputs 0.
- Array contents are not reset and start as X. The bench preloads through hierarchical access or `$readmemh`.

## Timing
- Reset values: `dmem_resp`=0, `dmem_rdata`=0, `dmem_err`=0, `busy`=0, state=IDLE, counter=0.
- Accept at cycle t; `dmem_resp` at t+`LATENCY`; next accept possible at t+`LATENCY`+1. Peak throughput is one transaction per `LATENCY`+1 cycles.
- `dmem_rdata` and `dmem_err` are registered, and are 0 outside the RESP cycle.
- `busy` is combinational from the request while in IDLE, and high in WAIT and RESP.
- Reset asserted mid-transaction: the state aborts immediately. No response is issued and the pending write is not committed. Array contents are preserved.

## Configuration
- `DMEM_OOB_ERR_EN` defined:
  - A latched address outside [`BASE_ADDR`, `BASE_ADDR`+4*`DEPTH_WORDS`) completes with normal latency and `dmem_resp`=1.
  - On that response, `dmem_err`=1 and `dmem_rdata`=0, and no write is performed.
- Not defined: out-of-range addresses alias modulo `DEPTH_WORDS` (upper bits ignored), and `dmem_err` is tied to 0.

## Test plan
- Reset, then preload word 0 = 32'hDEAD_BEEF. Read `BASE_ADDR`, rmask 4'hF, `LATENCY`=2 → `dmem_resp` exactly 2 cycles after accept, rdata 32'hDEAD_BEEF, single-cycle pulse.
- Write `BASE_ADDR`+4, wmask 4'b0110, wdata 32'h1122_3344 over 32'h0, then read the same word → 32'h0022_3300.
- Back-to-back: hold the next request during RESP → it is ignored in RESP and accepted the following cycle. With `LATENCY`=1, four reads → four resp pulses spaced 2 cycles apart.
- rmask and wmask both 4'hF on the same word holding 32'hAAAA_AAAA, wdata 32'h5555_5555 → rdata 32'hAAAA_AAAA; a subsequent read returns 32'h5555_5555.
- `rst_n` pulsed low during WAIT of a write → no `dmem_resp`, all outputs 0 at once, word unchanged.
- Read at `BASE_ADDR`+4*`DEPTH_WORDS`:
  - With `DMEM_OOB_ERR_EN`: resp with err=1, rdata 0.
  - Without: data of word 0, err=0.
